// File: rtl/bsg_skid_buffer_pkg.sv
// Shared types and constants for the two-entry enable-register skid buffer.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   state_e         FSM encoding, one state per occupancy level
//   occ_*_lp        occupancy values reported on count_o
//   state_count()   maps an FSM state to its occupancy

package bsg_skid_buffer_pkg;

  // The encoding is fixed at 2 bits because the state is held in a
  // bsg_dff_areset_en instance, and that register resets to all zeros.
  // Zero must therefore decode to eEmpty.
  typedef enum logic [1:0] {
    eEmpty = 2'd0,
    eBusy  = 2'd1,
    eFull  = 2'd2
  } state_e;

  localparam logic [1:0] occ_empty_lp = 2'd0;
  localparam logic [1:0] occ_one_lp   = 2'd1;
  localparam logic [1:0] occ_two_lp   = 2'd2;

  // Occupancy follows directly from the state. The unused encoding reads
  // as empty, so count_o can never report a value above two.
  function automatic logic [1:0] state_count(input state_e s);
    logic [1:0] c;
    c = occ_empty_lp;
    case (s)
      eEmpty:  c = occ_empty_lp;
      eBusy:   c = occ_one_lp;
      eFull:   c = occ_two_lp;
      default: c = occ_empty_lp;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bsg_dff_areset_en.sv
// Enabled D flip-flop bank with an asynchronous active-high clear to zero.
// Latency: 1 cycle from data_i to data_o when en_i is high.
// Backpressure: none; the register holds its value whenever en_i is low.
//
// Ports:
//   clk_i    rising-edge clock
//   reset_i  asynchronous active-high clear
//   en_i     load enable
//   data_i   next value
//   data_o   registered value

module bsg_dff_areset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o <= '0;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/bsg_skid_buffer_en.sv
// Two-entry ready/valid skid buffer in front of an enable-register stage.
// Latency: 1 cycle from accept to v_o/data_o when the buffer was empty.
// Backpressure: ready_o is a flop; it drops only when both entries are full.
//
// Ports:
//   clk_i    rising-edge clock
//   reset_i  asynchronous active-high reset
//   v_i      upstream word valid
//   data_i   upstream data
//   ready_o  registered; data_i is accepted when v_i and ready_o are both high
//   v_o      downstream word valid
//   data_o   downstream data, taken straight from the main register
//   yumi_i   downstream consumes data_o this cycle (only legal while v_o is high)
//   count_o  occupancy: 0, 1 or 2

module bsg_skid_buffer_en
  import bsg_skid_buffer_pkg::*;
#(
  parameter int width_p = -1
) (
  input  logic               clk_i,
  input  logic               reset_i,

  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,

  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,

  output logic [1:0]         count_o
);

  state_e             state_r;
  state_e             state_n;
  logic [1:0]         state_bits_r;
  logic               ready_r;
  logic               ready_n;
  logic               accept;
  logic               main_en;
  logic               skid_en;
  logic [width_p-1:0] main_n;
  logic [width_p-1:0] main_r;
  logic [width_p-1:0] skid_r;

  assign state_r = state_e'(state_bits_r);

  // ready_o is registered, so accept depends only on v_i and a flop.
  // Nothing combinational from v_i or yumi_i ever reaches an output.
  assign accept  = v_i & ready_r;

  // Next-state logic and register enables. Data only moves when an enable
  // is high; in every other case both registers hold their contents.
  always_comb begin
    state_n = state_r;
    main_en = 1'b0;
    skid_en = 1'b0;
    case (state_r)
      eEmpty: begin
        if (accept) begin
          state_n = eBusy;
          main_en = 1'b1;
        end
      end
      eBusy: begin
        if (accept && yumi_i) begin
          // The consumed word leaves and the new word replaces it on the
          // same edge, so occupancy stays at one.
          state_n = eBusy;
          main_en = 1'b1;
        end else if (accept) begin
          // The consumer is stalled. Park the new word in the skid
          // register so main keeps presenting the older word.
          state_n = eFull;
          skid_en = 1'b1;
        end else if (yumi_i) begin
          state_n = eEmpty;
        end
      end
      eFull: begin
        // ready is low here, so accept cannot happen. The only way out
        // is a consume, which promotes the skid word into main.
        if (yumi_i) begin
          state_n = eBusy;
          main_en = 1'b1;
        end
      end
      default: begin
        state_n = eEmpty;
      end
    endcase
  end

  // Main loads from upstream, except when it refills from the skid
  // register on the way out of eFull.
  assign main_n  = (state_r == eFull) ? skid_r : data_i;

  // ready resets to 0 and first rises at the edge after reset release.
  // This keeps a word offered during the release cycle from being accepted.
  assign ready_n = (state_n != eFull);

  bsg_dff_areset_en #(.width_p(2)) state_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (1'b1),
    .data_i  (state_n),
    .data_o  (state_bits_r)
  );

  bsg_dff_areset_en #(.width_p(1)) ready_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (1'b1),
    .data_i  (ready_n),
    .data_o  (ready_r)
  );

  bsg_dff_areset_en #(.width_p(width_p)) main_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (main_en),
    .data_i  (main_n),
    .data_o  (main_r)
  );

  bsg_dff_areset_en #(.width_p(width_p)) skid_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (skid_en),
    .data_i  (data_i),
    .data_o  (skid_r)
  );

  assign ready_o = ready_r;
  assign v_o     = (state_r != eEmpty);
  assign data_o  = main_r;
  assign count_o = state_count(state_r);

  // A consume with nothing valid on the output is a protocol violation
  // by the consumer.
  yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
  );

endmodule
